// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file with busy scoreboard.
package regfile_mp_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int ZERO_IDX   = 0;
    localparam int NUM_WR     = 2;
endpackage

// File: rtl/regfile_mp_scoreboard.sv
// One busy bit per register: set by a reservation, cleared by a write.
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_sel,
    input  logic [2**ADDR_W-1:0]   clr,
    output logic [2**ADDR_W-1:0]   busy
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] busy_nxt;

    // A reservation is the newer producer, so set wins over a same-edge clear.
    always_comb begin
        set_vec = '0;
        if (rsv_en && (rsv_sel != ADDR_W'(ZERO_IDX)))
            set_vec[rsv_sel] = 1'b1;
        busy_nxt = (busy & ~clr) | set_vec;
        busy_nxt[ZERO_IDX] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end
endmodule

// File: rtl/regfile_mp.sv
// Register file: 2 write ports, NUM_RD combinational read ports, per-register busy bits.
// Optional write-to-read bypass is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_sel,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_sel,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_sel,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]             regs [DEPTH];
    logic [NUM_WR-1:0][DEPTH-1:0]  wr_hit;
    logic [DEPTH-1:0]              wr_clr;
    logic [DEPTH-1:0]              busy;

    // Decode each write port to a one-hot target; index 0 never matches.
    always_comb begin
        wr_hit = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en[p] && (wr_sel[p*ADDR_W +: ADDR_W] == ADDR_W'(i)))
                    wr_hit[p][i] = 1'b1;
            end
        end
        wr_clr = wr_hit[0] | wr_hit[1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_hit[1][i])
                    regs[i] <= wr_data[DATA_W +: DATA_W];
                else if (wr_hit[0][i])
                    regs[i] <= wr_data[0 +: DATA_W];
            end
        end
    end

    regfile_mp_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clock   (clock),
        .reset   (reset),
        .rsv_en  (rsv_en),
        .rsv_sel (rsv_sel),
        .clr     (wr_clr),
        .busy    (busy)
    );

    always_comb begin : rd_mux
        logic [ADDR_W-1:0] sel;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            sel = rd_sel[k*ADDR_W +: ADDR_W];
            rd_data[k*DATA_W +: DATA_W] = regs[sel];
            rd_busy[k] = busy[sel];
`ifdef REGFILE_MP_BYPASS_EN
            // A same-cycle write retires the old producer unless a new reservation lands too.
            if (wr_hit[1][sel] || wr_hit[0][sel]) begin
                rd_data[k*DATA_W +: DATA_W] = wr_hit[1][sel] ? wr_data[DATA_W +: DATA_W]
                                                             : wr_data[0 +: DATA_W];
                rd_busy[k] = rsv_en && (rsv_sel == sel);
            end
`endif
            if (reset || (sel == ADDR_W'(ZERO_IDX))) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k] = 1'b0;
            end
        end
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  2  write enable per write port (port 0, port 1).
REQ-007 SHALL have port wr_sel  input  2*ADDR_W  write index per port; port p at bits [p*ADDR_W +: ADDR_W].
REQ-008 SHALL have port wr_data  input  2*DATA_W  write data per port, packed as wr_sel.
REQ-009 SHALL have port rsv_en  input  1  reserve request; marks destination busy.
REQ-010 SHALL have port rsv_sel  input  ADDR_W  register index to reserve.
REQ-011 SHALL have port rd_sel  input  NUM_RD*ADDR_W  read index per read port.
REQ-012 SHALL have port rd_data  output  NUM_RD*DATA_W  read data per read port.
REQ-013 SHALL have port rd_busy  output  NUM_RD  busy flag of the register selected on each read port.

Function
REQ-014 Reads SHALL be combinational from rd_sel; register state changes SHALL take effect on the next rising edge.
REQ-015 Register 0 SHALL always read 0 and never be busy; writes and reserves to index 0 SHALL be ignored.
REQ-016 Both write ports to different indices in one cycle SHALL both commit.
REQ-017 Both write ports to the same nonzero index in one cycle SHALL commit port 1 data; port 0 is discarded.
REQ-018 A write to index i SHALL clear busy[i] on the same edge.
REQ-019 rsv_en with nonzero rsv_sel SHALL set busy[rsv_sel] on the edge.
REQ-020 Reserve and write to the same index in one cycle SHALL leave busy set, since the reservation is the newer producer; the data still commits.
REQ-021 A reserve of an already-busy index SHALL keep it busy; busy SHALL be one bit, not a count.
REQ-022 Writes SHALL be accepted whether or not the target is busy.
REQ-023 rd_busy[k] SHALL equal busy[rd_sel[k]] before the edge, subject to REQ-027.

Reset
REQ-024 Asserting reset SHALL immediately clear every register and every busy bit to 0, independent of clock.
REQ-025 While reset is high, writes and reserves SHALL be ignored; rd_data and rd_busy SHALL read 0.
REQ-026 Reset asserted in the same cycle as a write or reserve SHALL win; no state from that cycle survives.

Configuration
REQ-027 With macro REGFILE_MP_BYPASS_EN defined, a read whose index matches an enabled nonzero write in the same cycle SHALL return that write data (port 1 data on a double match). The read SHALL also report rd_busy = 0 unless rsv_en targets the same index.
REQ-028 Without REGFILE_MP_BYPASS_EN, reads SHALL return only pre-edge stored state, and there SHALL be no combinational path from wr_* or rsv_* to rd_*.

Structure
REQ-029 Package regfile_mp_pkg SHALL hold the default DATA_W/ADDR_W/NUM_RD constants, the zero-register index constant, and the write-port count constant (2).
REQ-030 The busy-bit logic (REQ-018..021) SHALL be sub-module regfile_mp_scoreboard, with reserve and clear inputs and a busy vector output.
REQ-031 Storage and read muxing SHALL remain in regfile_mp.

Verification
REQ-032 Reset, then read all 32 indices on both ports -> rd_data = 0 and rd_busy = 0 everywhere.
REQ-033 Write x5 = 0xDEADBEEF on port 0 and x0 = 0x1234 on port 1, then read x5 and x0 next cycle -> 0xDEADBEEF and 0.
REQ-034 Both ports write x7 in one cycle (port 0 = 0x1111, port 1 = 0x2222), then read x7 -> 0x2222.
REQ-035 Reserve x3, then read x3 (busy = 1). Write x3 = 0x55 -> busy = 0 and data = 0x55 next cycle. Reserve and write x3 together -> busy stays 1.
REQ-036 With BYPASS_EN, write x9 = 0xA5A5A5A5 while reading x9 in the same cycle -> rd_data = 0xA5A5A5A5 combinationally. Without BYPASS_EN -> the old value that cycle and the new value next cycle.
REQ-037 Write x4 = 0x77 and reserve x6, then pulse reset mid-cycle with no clock edge -> x4 and x6 read 0 and busy = 0 immediately.
